// File: rtl/mem_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_pkg : shared FSM encoding and line constants for mem_arbiter   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package mem_pkg;

  localparam int          LINE_WORDS      = 8;
  localparam logic [31:0] LINE_MASK       = 32'hFFFF_FFE0;
  localparam int          TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    BURST  = 3'd2,
    STORE  = 3'd3,
    FINISH = 3'd4,
    ERROR  = 3'd5
  } state_e;

  // Loads fetch a whole line, stores hit the exact word address.
  function automatic logic [31:0] req_mem_addr(input logic [31:0] addr, input logic store);
    return store ? addr : (addr & LINE_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin grant, bit0 preferred after rst  |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic r_prefer_hi;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = r_prefer_hi ? 2'b10 : 2'b01;
  end

  // After granting bit0 the next contested cycle favours bit1, and vice versa.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_prefer_hi <= 1'b0;
    else if (en && (|req))
      r_prefer_hi <= gnt[0];
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_arbiter : I/D cache arbiter for line loads and word stores     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_STORE,
  input  logic [31:0] REQ_ADDR0,
  input  logic [31:0] REQ_ADDR1,
  input  logic [31:0] REQ_WDATA0,
  input  logic [31:0] REQ_WDATA1,
  output logic [1:0]  GNT,
  output logic [1:0]  RSP_VALID,
  output logic [2:0]  RSP_IDX,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  DONE,
  output logic        ERR,
  output logic        MEM_VALID,
  output logic        MEM_LOAD,
  output logic        MEM_STORE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ADDR_ACK,
  input  logic        MEM_DATA_VALID,
  input  logic [31:0] MEM_RDATA,
  input  logic [2:0]  MEM_DATA_IDX,
  output logic        MEM_DATA_ACK
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  state_e             r_state;
  logic [1:0]         r_gnt;
  logic               r_store;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_valid;
  logic               r_mem_load;
  logic               r_mem_store;
  logic [1:0]         r_done;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_exp_idx;

  logic [1:0]  w_arb_gnt;
  logic        w_sel_id;
  logic        w_sel_store;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_accept;
  logic        w_hs;
  logic        w_waiting;
  logic        w_timeout;
  logic        w_last;
  logic        w_finish;

  rr_arbiter2 u_rr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req   (REQ_VALID),
    .en    (r_state == IDLE),
    .gnt   (w_arb_gnt)
  );

  assign w_sel_id    = w_arb_gnt[1];
  assign w_sel_store = REQ_STORE[w_sel_id];
  assign w_sel_addr  = w_sel_id ? REQ_ADDR1 : REQ_ADDR0;
  assign w_sel_wdata = w_sel_id ? REQ_WDATA1 : REQ_WDATA0;

  // Only the expected word is forwarded; anything out of sequence is left unacknowledged.
  assign w_accept = (r_state == BURST) && MEM_DATA_VALID && (MEM_DATA_IDX == r_exp_idx);
  assign w_last   = (r_exp_idx == 3'(LINE_WORDS - 1));

  always_comb begin
    w_hs      = 1'b0;
    w_waiting = 1'b1;
    case (r_state)
      ADDR:    w_hs = MEM_ADDR_ACK;
      BURST:   w_hs = w_accept;
      STORE:   w_hs = MEM_DATA_VALID;
      default: w_waiting = 1'b0;
    endcase
  end

  assign w_timeout = w_waiting && !w_hs && (r_cnt == c_cnt_w'(TIMEOUT - 1));
  assign w_finish  = (w_accept && w_last) || ((r_state == STORE) && MEM_DATA_VALID);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_store     <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_valid <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_store <= 1'b0;
      r_done      <= 2'b00;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_exp_idx   <= 3'd0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 1'b0;
      r_cnt  <= (w_waiting && !w_hs && !w_timeout) ? r_cnt + c_cnt_w'(1) : '0;
      case (r_state)
        IDLE: begin
          if (|REQ_VALID) begin
            r_gnt       <= w_arb_gnt;
            r_store     <= w_sel_store;
            r_mem_addr  <= req_mem_addr(w_sel_addr, w_sel_store);
            r_mem_wdata <= w_sel_wdata;
            r_mem_valid <= 1'b1;
            r_mem_load  <= !w_sel_store;
            r_mem_store <= w_sel_store;
            r_exp_idx   <= 3'd0;
            r_state     <= ADDR;
          end
        end
        ADDR:    if (MEM_ADDR_ACK) r_state <= r_store ? STORE : BURST;
        BURST:   if (w_accept && !w_last) r_exp_idx <= r_exp_idx + 3'd1;
        STORE:   ;
        default: r_state <= IDLE;
      endcase
      // Completion and timeout both release the bus and report to the owner.
      if (w_finish || w_timeout) begin
        r_state     <= w_finish ? FINISH : ERROR;
        r_done      <= r_gnt;
        r_err       <= w_timeout;
        r_gnt       <= 2'b00;
        r_mem_valid <= 1'b0;
        r_mem_load  <= 1'b0;
        r_mem_store <= 1'b0;
      end
    end
  end

  assign GNT          = r_gnt;
  assign DONE         = r_done;
  assign ERR          = r_err;
  assign MEM_VALID    = r_mem_valid;
  assign MEM_LOAD     = r_mem_load;
  assign MEM_STORE    = r_mem_store;
  assign MEM_ADDR     = r_mem_addr;
  assign MEM_WDATA    = r_mem_wdata;
  assign RSP_VALID    = w_accept ? r_gnt : 2'b00;
  assign RSP_IDX      = w_accept ? MEM_DATA_IDX : 3'd0;
  assign RSP_DATA     = w_accept ? MEM_RDATA : 32'd0;
  assign MEM_DATA_ACK = w_accept || ((r_state == STORE) && MEM_DATA_VALID);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter                  |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        CLK, RST_N;
  logic [1:0]  REQ_VALID, REQ_STORE;
  logic [31:0] REQ_ADDR0, REQ_ADDR1, REQ_WDATA0, REQ_WDATA1;
  logic [1:0]  GNT, RSP_VALID, DONE;
  logic [2:0]  RSP_IDX, MEM_DATA_IDX;
  logic [31:0] RSP_DATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        ERR, MEM_VALID, MEM_LOAD, MEM_STORE;
  logic        MEM_ADDR_ACK, MEM_DATA_VALID, MEM_DATA_ACK;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [2:0]  idx;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done0  = 0;
  int   n_done1  = 0;
  int   n_err    = 0;
  int   cyc, ph;
  bit   seen;
  logic [1:0] w, eg, ed;

  mem_arbiter dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .REQ_VALID      (REQ_VALID),
    .REQ_STORE      (REQ_STORE),
    .REQ_ADDR0      (REQ_ADDR0),
    .REQ_ADDR1      (REQ_ADDR1),
    .REQ_WDATA0     (REQ_WDATA0),
    .REQ_WDATA1     (REQ_WDATA1),
    .GNT            (GNT),
    .RSP_VALID      (RSP_VALID),
    .RSP_IDX        (RSP_IDX),
    .RSP_DATA       (RSP_DATA),
    .DONE           (DONE),
    .ERR            (ERR),
    .MEM_VALID      (MEM_VALID),
    .MEM_LOAD       (MEM_LOAD),
    .MEM_STORE      (MEM_STORE),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_WDATA      (MEM_WDATA),
    .MEM_ADDR_ACK   (MEM_ADDR_ACK),
    .MEM_DATA_VALID (MEM_DATA_VALID),
    .MEM_RDATA      (MEM_RDATA),
    .MEM_DATA_IDX   (MEM_DATA_IDX),
    .MEM_DATA_ACK   (MEM_DATA_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Response monitor: every forwarded word must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (DONE[0]) n_done0++;
    if (DONE[1]) n_done1++;
    if (ERR) n_err++;
    if (RSP_VALID != 2'b00) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(RSP_VALID), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("rsp_valid", 32'(RSP_VALID), 32'(mon_e.gnt));
        check("rsp_idx", 32'(RSP_IDX), 32'(mon_e.idx));
        check("rsp_data", RSP_DATA, mon_e.data);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({GNT, RSP_VALID, DONE, ERR, MEM_VALID, MEM_LOAD, MEM_STORE,
                               MEM_DATA_ACK, RSP_IDX}), 32'd0);
    check({tag, "_mem_addr"}, MEM_ADDR, 32'd0);
    check({tag, "_mem_wdata"}, MEM_WDATA, 32'd0);
    check({tag, "_rsp_data"}, RSP_DATA, 32'd0);
  endtask

  task automatic wait_mem_valid(input string tag);
    int i = 0;
    do begin
      @(negedge CLK);
      i++;
    end while (!MEM_VALID && i < 10);
    check(tag, 32'(MEM_VALID), 32'd1);
  endtask

  // Line load; ord holds the beat index sequence, one nibble per beat, LSB first.
  task automatic run_load(input int id, input logic [1:0] req_mask, input logic [1:0] hold_mask,
                          input logic [31:0] addr, input logic [31:0] base,
                          input logic [63:0] ord, input int n, input bit finish);
    logic [1:0] g;
    logic [2:0] ix;
    int         exp_idx;
    int         i;
    rsp_t       r;
    g = (id == 0) ? 2'b01 : 2'b10;
    @(posedge CLK); #1;
    REQ_STORE = 2'b00;
    if (id == 0) REQ_ADDR0 = addr; else REQ_ADDR1 = addr;
    REQ_VALID    = req_mask;
    MEM_ADDR_ACK = 1'b1;
    wait_mem_valid("load_mem_valid");
    check("load_gnt", 32'(GNT), 32'(g));
    check("load_mem_load", 32'(MEM_LOAD), 32'd1);
    check("load_mem_addr", MEM_ADDR, addr & 32'hFFFF_FFE0);
    exp_idx = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      if (k == 0) begin
        REQ_VALID    = hold_mask;
        MEM_ADDR_ACK = 1'b0;
      end
      ix             = ord[4*k +: 3];
      MEM_DATA_VALID = 1'b1;
      MEM_DATA_IDX   = ix;
      MEM_RDATA      = base + 32'(ix);
      if (32'(ix) == exp_idx) begin
        r = '{gnt: g, idx: ix, data: base + 32'(ix)};
        sb.push_back(r);
      end
      @(negedge CLK);
      check("data_ack", 32'(MEM_DATA_ACK), (32'(ix) == exp_idx) ? 32'd1 : 32'd0);
      if (32'(ix) == exp_idx) exp_idx++;
    end
    if (finish) begin
      @(posedge CLK); #1;
      MEM_DATA_VALID = 1'b0;
      i = 0;
      do begin
        @(negedge CLK);
        i++;
      end while (DONE == 2'b00 && i < 4);
      check("load_done", 32'(DONE), 32'(g));
      check("load_gnt_drop", 32'(GNT), 32'd0);
      check("load_mem_valid_drop", 32'(MEM_VALID), 32'd0);
      check("load_sb_drained", 32'(sb.size()), 32'd0);
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
    end
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = '0; REQ_STORE = '0;
    REQ_ADDR0 = '0; REQ_ADDR1 = '0; REQ_WDATA0 = '0; REQ_WDATA1 = '0;
    MEM_ADDR_ACK = 1'b0; MEM_DATA_VALID = 1'b0; MEM_RDATA = '0; MEM_DATA_IDX = '0;
    repeat (2) @(negedge CLK);
    check_idle_outputs("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check_idle_outputs("post_reset");

    // Contention straight after reset: ADDR, STORE, FINISH, IDLE repeating, alternating owners.
    @(posedge CLK); #1;
    REQ_STORE = 2'b11; REQ_ADDR0 = 32'h0000_201C; REQ_ADDR1 = 32'h0000_3004;
    REQ_WDATA0 = 32'h1111_0000; REQ_WDATA1 = 32'h2222_0000;
    MEM_ADDR_ACK = 1'b1; MEM_DATA_VALID = 1'b1; REQ_VALID = 2'b11;
    for (int c = 0; c < 11; c++) begin
      @(negedge CLK);
      ph = (c - 1) % 4;
      w  = (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      eg = (c > 0 && ph < 2) ? w : 2'b00;
      ed = (c > 0 && ph == 2) ? w : 2'b00;
      check("rr_gnt", 32'(GNT), 32'(eg));
      check("rr_done", 32'(DONE), 32'(ed));
      if (c > 0 && ph == 0) begin
        check("rr_mem_addr", MEM_ADDR, w[0] ? 32'h0000_201C : 32'h0000_3004);
        check("rr_mem_wdata", MEM_WDATA, w[0] ? 32'h1111_0000 : 32'h2222_0000);
        check("rr_mem_store", 32'(MEM_STORE), 32'd1);
      end
    end
    REQ_VALID = 2'b00;
    repeat (3) @(negedge CLK);
    MEM_DATA_VALID = 1'b0; MEM_ADDR_ACK = 1'b0;

    // I-cache line load, request dropped after grant, memory acks at once.
    n_done0 = 0; n_done1 = 0;
    run_load(0, 2'b01, 2'b00, 32'h0000_0044, 32'hA000_0000, 64'h7654_3210, 8, 1'b1);
    repeat (3) @(negedge CLK);
    check("icache_done0_once", 32'(n_done0), 32'd1);
    check("icache_done1_none", 32'(n_done1), 32'd0);

    // D-cache single-word store with delayed acks.
    @(posedge CLK); #1;
    REQ_VALID = 2'b10; REQ_STORE = 2'b10; REQ_ADDR1 = 32'h0000_0100; REQ_WDATA1 = 32'hDEAD_BEEF;
    wait_mem_valid("store_mem_valid");
    check("store_gnt", 32'(GNT), 32'h2);
    check("store_mem_store", 32'(MEM_STORE), 32'd1);
    check("store_mem_load", 32'(MEM_LOAD), 32'd0);
    check("store_mem_addr", MEM_ADDR, 32'h0000_0100);
    check("store_mem_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    REQ_VALID = 2'b00;
    @(posedge CLK); #1; MEM_ADDR_ACK = 1'b1;
    @(posedge CLK); #1; MEM_ADDR_ACK = 1'b0;
    @(negedge CLK);
    check("store_no_early_done", 32'(DONE), 32'd0);
    check("store_no_early_ack", 32'(MEM_DATA_ACK), 32'd0);
    @(posedge CLK); #1; MEM_DATA_VALID = 1'b1;
    @(negedge CLK);
    check("store_data_ack", 32'(MEM_DATA_ACK), 32'd1);
    @(posedge CLK); #1; MEM_DATA_VALID = 1'b0;
    @(negedge CLK);
    check("store_done", 32'(DONE), 32'h2);
    check("store_gnt_drop", 32'(GNT), 32'd0);

    // Out-of-order beat (0,2,1,2,3..7) on a D-cache load.
    run_load(1, 2'b10, 2'b00, 32'h1234_567C, 32'hB000_0000, 64'h0000_0007_6543_2120, 9, 1'b1);

    // Address ack withheld: error after TIMEOUT cycles in ADDR.
    @(posedge CLK); #1;
    REQ_STORE = 2'b00; REQ_ADDR0 = 32'h0000_0500; REQ_VALID = 2'b01;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (ERR) seen = 1'b1;
      else if (MEM_VALID) begin
        cyc++;
        REQ_VALID = 2'b00;
      end
    end
    check("timeout_err_seen", 32'(seen), 32'd1);
    check("timeout_cycles", 32'(cyc), 32'd64);
    check("timeout_done", 32'(DONE), 32'h1);
    check("timeout_strobes", 32'({GNT, MEM_VALID, MEM_LOAD}), 32'd0);
    @(negedge CLK);
    check("timeout_pulse_end", 32'({ERR, DONE, MEM_VALID}), 32'd0);

    // Reset while index 3 is on the bus.
    run_load(0, 2'b01, 2'b00, 32'h0000_8008, 32'hC000_0000, 64'h210, 3, 1'b0);
    n_done0 = 0; n_done1 = 0; n_err = 0;
    @(posedge CLK); #1;
    MEM_DATA_IDX = 3'd3; MEM_RDATA = 32'hC000_0003; MEM_DATA_VALID = 1'b1; RST_N = 1'b0;
    #1;
    check_idle_outputs("midburst_reset");
    check("midburst_sb_drained", 32'(sb.size()), 32'd0);
    @(posedge CLK); #1; MEM_DATA_VALID = 1'b0;
    @(posedge CLK); #1; RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("midburst_no_done", 32'(n_done0 + n_done1), 32'd0);
    check("midburst_no_err", 32'(n_err), 32'd0);
    run_load(0, 2'b11, 2'b11, 32'h0000_9010, 32'hD000_0000, 64'h7654_3210, 8, 1'b1);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: RST_N  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: REQ_VALID  input  2  per-requester request; bit0 = instruction cache, bit1 = data cache.
REQ-004 SHALL have ports: REQ_STORE  input  2  per-requester op: 0 = 8-word line load, 1 = single-word store.
REQ-005 SHALL have ports: REQ_ADDR0, REQ_ADDR1  input  32 each  request byte address.
REQ-006 SHALL have ports: REQ_WDATA0, REQ_WDATA1  input  32 each  store data.
REQ-007 SHALL have ports: GNT  output  2  one-hot grant, held for the whole transaction.
REQ-008 SHALL have ports: RSP_VALID  output  2  one-hot, one-cycle pulse per delivered load word.
REQ-009 SHALL have ports: RSP_IDX  output  3  word index within line; RSP_DATA  output  32  word data.
REQ-010 SHALL have ports: DONE  output  2  one-cycle completion pulse; ERR  output  1  one-cycle timeout pulse.
REQ-011 SHALL have ports: MEM_VALID, MEM_LOAD, MEM_STORE  output  1 each  memory command strobes.
REQ-012 SHALL have ports: MEM_ADDR, MEM_WDATA  output  32 each; MEM_ADDR_ACK, MEM_DATA_VALID  input  1 each.
REQ-013 SHALL have ports: MEM_RDATA  input  32; MEM_DATA_IDX  input  3; MEM_DATA_ACK  output  1.
REQ-014 SHALL have parameter TIMEOUT, default 64, max cycles waiting on any memory handshake.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, BURST, STORE, FINISH, ERROR.
REQ-016 IDLE: if any REQ_VALID, SHALL grant round-robin, preferring requester not granted last; after reset bit0 preferred; enter ADDR next edge.
REQ-017 Both requests in same cycle SHALL resolve in one cycle; loser stays pending, not dropped.
REQ-018 On grant SHALL latch requester id, op, data and line address = REQ_ADDR & 32'hFFFFFFE0 for loads, unmasked for stores.
REQ-019 ADDR: SHALL drive MEM_VALID=1, MEM_LOAD or MEM_STORE per op, MEM_ADDR latched; on MEM_ADDR_ACK go BURST (load) or STORE (store).
REQ-020 BURST: SHALL expect MEM_DATA_IDX sequential 0..7; on MEM_DATA_VALID with matching index, forward word to granted requester same cycle (RSP_VALID, RSP_IDX, RSP_DATA combinational) and pulse MEM_DATA_ACK.
REQ-021 Out-of-order MEM_DATA_IDX SHALL be ignored: no RSP_VALID, no ACK, expected index unchanged.
REQ-022 After index 7 accepted SHALL go FINISH; FINISH pulses DONE for granted requester, drops GNT and MEM_VALID, returns IDLE.
REQ-023 STORE: SHALL drive MEM_WDATA; on MEM_DATA_VALID pulse MEM_DATA_ACK, go FINISH.
REQ-024 Wait counter SHALL reset on each state entry and each accepted handshake; reaching TIMEOUT in ADDR, BURST or STORE SHALL go ERROR.
REQ-025 ERROR: SHALL pulse ERR and DONE for granted requester one cycle, drop all memory strobes, return IDLE.
REQ-026 Requester dropping REQ_VALID mid-transaction SHALL NOT abort it.
REQ-027 New grant SHALL NOT be issued in the FINISH cycle; minimum one IDLE cycle between transactions.
REQ-028 Load latency: grant to first RSP_VALID SHALL be 2 cycles plus memory ack delays.

Reset
REQ-029 RST_N low SHALL immediately force IDLE, all outputs 0, counter 0, expected index 0, round-robin pointer to bit0.
REQ-030 Reset mid-burst SHALL abandon the transaction without DONE or ERR.

Structure
REQ-031 State encoding, LINE_WORDS=8, line mask and TIMEOUT default SHALL live in shared package mem_pkg.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter2; FSM and datapath stay in mem_arbiter.

Verification
REQ-033 I-cache load 0x0000_0044, memory acks immediately -> MEM_ADDR=0x0000_0040, RSP_VALID[0] idx 0..7, DONE[0] once.
REQ-034 Both requesters valid after reset -> GNT=01 first, then GNT=10 after one IDLE cycle.
REQ-035 D-cache store 0x100 data 0xDEADBEEF -> MEM_STORE=1, MEM_WDATA=0xDEADBEEF, DONE[1] after MEM_DATA_VALID.
REQ-036 Memory sends idx 0,2,1,... -> idx 2 ignored, no MEM_DATA_ACK for it, all 8 words delivered in order.
REQ-037 MEM_ADDR_ACK withheld 64 cycles -> ERR and DONE[granted] pulse, return IDLE.
REQ-038 RST_N low at idx 3 -> all outputs 0 immediately, next request starts at idx 0.
